accum_sequencer: RTL and testbench
==================================

# accum_sequencer

Control block for the multi-picture partial-sum accumulator. It counts partial-sum beats per output pixel and drives the accumulator's first-beat load strobe. While no beat is accepted, it forces the accumulator input to zero so the running sum holds. It flags when the accumulator output holds a finished sum and stalls the upstream convolution datapath until downstream accepts that sum. It sits between the convolution engine's partial-sum stream and the accumulator/output packer.

## Interface
Parameters:
- CNT_W, 10: width of beat counter and cfg_beats.
- OUT_W, 16: width of output-pixel counter and cfg_outputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg and begins a layer; ignored unless IDLE.
- cfg_beats  in  CNT_W  partial-sum beats per output pixel; 0 treated as 1.
- cfg_outputs  in  OUT_W  output pixels per layer; 0 means immediate done.
- beat_valid  in  1  upstream partial sum present on the accumulator input.
- beat_ready  out  1  beat accepted this cycle when beat_valid & beat_ready.
- first_beat  out  1  to accumulator load strobe: load instead of add.
- data_zero  out  1  forces accumulator input to zero (hold).
- out_valid  out  1  accumulator output holds a complete sum.
- out_ready  in  1  downstream consumes the sum.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after last sum consumed.
- stall_cycles  out  32  performance count (see Configuration).

## Operation
- The datapath registers are assumed present: accumulator loads on first_beat, otherwise adds its input every cycle.
- States:
  - IDLE: beat_ready=0, data_zero=1, first_beat=0.
  - RUN: accepting beats of the current pixel.
  - HOLD: finished sum on accumulator output.
- Transitions:
  - IDLE -> RUN on start with cfg_outputs != 0. Latch cfg_beats (0 -> 1) and cfg_outputs. Clear beat_cnt and out_cnt.
  - IDLE + start with cfg_outputs = 0: done pulses next cycle, stay IDLE.
  - RUN: on accepted beat, beat_cnt++. If beat_cnt == beats-1, clear beat_cnt and go to HOLD.
  - HOLD & out_ready: out_cnt++.
    - If out_cnt was outputs-1: go IDLE and pulse done next cycle.
    - Otherwise, if the next pixel's first beat is accepted this cycle, handle it as in RUN (stay in HOLD if beats=1). If not, go RUN.
- Outputs:
  - beat_ready = RUN | (HOLD & out_ready & out_cnt != outputs-1).
  - first_beat = beat_valid & beat_ready & (beat_cnt == 0). Combinational.
  - data_zero = ~(beat_valid & beat_ready). Combinational.
  - out_valid = (state == HOLD). Registered.
- Start pulses while busy have no effect. cfg inputs are sampled only at an accepted start.

## Timing
- Reset (asynchronous): state=IDLE, counters=0, out_valid=0, busy=0, done=0, stall_cycles=0.
- Combinational outputs in reset: beat_ready=0, first_beat=0, data_zero=1.
- Latency:
  - The last beat accepted at edge N puts the sum on the accumulator output after N.
  - out_valid is high in the cycle following N.
- Throughput:
  - With beats=1 and out_ready held high, one sum per cycle, no bubbles.
  - With beats=B, one sum per B cycles.
- Boundaries:
  - out_valid stays high until out_ready, and the sum is held by data_zero=1.
  - beat_valid low mid-pixel: beat_cnt holds, data_zero=1, sum unchanged.
  - Reset asserted mid-layer aborts immediately. No done pulse.
  - beat_cnt wraps only via the beats-1 compare.

## Configuration
- ACC_PERF_CNT_EN defined: stall_cycles increments each cycle with state == HOLD & ~out_ready. It saturates at 0xFFFFFFFF and clears on accepted start and on reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

## Test plan
- Reset then start, cfg_beats=3, cfg_outputs=2, beat_valid always 1, out_ready always 1:
  - first_beat high on beats 0 and 3.
  - out_valid high in cycles 4 and 7 after the first accepted beat.
  - done pulses one cycle after the second consume.
- cfg_beats=1, cfg_outputs=4, out_ready=1: out_valid high 4 consecutive cycles, beat_ready never drops, done once.
- cfg_beats=2, out_ready held low 5 cycles at first HOLD:
  - beat_ready=0 and data_zero=1 throughout; out_valid stays high.
  - With ACC_PERF_CNT_EN, stall_cycles=5.
- beat_valid toggling 1,0,0,1 with cfg_beats=2: the second beat is accepted on cycle 3, first_beat fires only once, out_valid follows.
- start with cfg_outputs=0 -> busy stays 0, done pulses once. start with cfg_beats=0 -> behaves as beats=1.
- Assert rst mid-RUN (beat_cnt=1) asynchronously: all outputs return to reset values before the next clk edge. A new start runs a full layer correctly.

Source files
------------

// File: rtl/accum_sequencer.sv
// Beat/pixel sequencer for the partial-sum accumulator: drives load strobe, input hold and output handshake.
// Optional ACC_PERF_CNT_EN builds a saturating counter of cycles spent waiting on downstream.
module accum_sequencer #(
  parameter int CNT_W = 10,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_beats,
  input  logic [OUT_W-1:0] cfg_outputs,
  input  logic             beat_valid,
  output logic             beat_ready,
  output logic             first_beat,
  output logic             data_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      stall_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] beats_r, beats_n, beat_cnt, beat_cnt_n;
  logic [OUT_W-1:0] outputs_r, outputs_n, out_cnt, out_cnt_n;
  logic             done_n;
  logic             accept, last_beat, last_out;

  assign last_beat = (beat_cnt == beats_r - CNT_W'(1));
  assign last_out  = (out_cnt == outputs_r - OUT_W'(1));

  // In HOLD a consume that is not the layer's last frees the accumulator for the next pixel's first beat.
  assign beat_ready = (state == RUN) || ((state == HOLD) && out_ready && !last_out);
  assign accept     = beat_valid && beat_ready;
  assign first_beat = accept && (beat_cnt == '0);
  assign data_zero  = !accept;
  assign busy       = (state != IDLE);

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a value unassigned and infers a latch.
    state_n    = state;
    beats_n    = beats_r;
    outputs_n  = outputs_r;
    beat_cnt_n = beat_cnt;
    out_cnt_n  = out_cnt;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          beats_n    = (cfg_beats == '0) ? CNT_W'(1) : cfg_beats;
          outputs_n  = cfg_outputs;
          beat_cnt_n = '0;
          out_cnt_n  = '0;
          if (cfg_outputs == '0) done_n  = 1'b1;
          else                   state_n = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_beat) begin
            beat_cnt_n = '0;
            state_n    = HOLD;
          end else begin
            beat_cnt_n = beat_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_cnt_n = out_cnt + OUT_W'(1);
          if (last_out) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (accept) begin
            // beat_cnt is zero here, so last_beat means a single-beat pixel
            if (last_beat) begin
              beat_cnt_n = '0;
            end else begin
              beat_cnt_n = beat_cnt + CNT_W'(1);
              state_n    = RUN;
            end
          end else begin
            state_n = RUN;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beats_r   <= '0;
      outputs_r <= '0;
      beat_cnt  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      beats_r   <= beats_n;
      outputs_r <= outputs_n;
      beat_cnt  <= beat_cnt_n;
      out_cnt   <= out_cnt_n;
      out_valid <= (state_n == HOLD);
      done      <= done_n;
    end
  end

`ifdef ACC_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           stall_q <= '0;
    else if ((state == IDLE) && start)                 stall_q <= '0;
    else if ((state == HOLD) && !out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_accum_sequencer.sv
// Scoreboard bench for accum_sequencer: expected pixel sums are queued as beats are accepted and
// compared against a behavioural accumulator when the sequencer presents out_valid & out_ready.
module tb_accum_sequencer;

  localparam int CNT_W = 10;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] cfg_beats;
  logic [OUT_W-1:0] cfg_outputs;
  logic             beat_valid;
  logic             beat_ready;
  logic             first_beat;
  logic             data_zero;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [31:0]      stall_cycles;

  logic [15:0]      din;
  logic [31:0]      acc;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit  scb_en    = 1'b0;
  bit  det_mode  = 1'b0;
  bit  done_due  = 1'b0;
  int  cyc       = 0;
  int  first_cyc = -1;
  int  cur_b     = 1;
  int  cur_n     = 0;
  int  popped    = 0;
  int  done_cnt  = 0;
  int  stall_obs = 0;

  accum_sequencer #(.CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_beats    (cfg_beats),
    .cfg_outputs  (cfg_outputs),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .first_beat   (first_beat),
    .data_zero    (data_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accumulator datapath the sequencer controls: load on first_beat, else add the (possibly zeroed) input.
  always @(posedge clk or posedge rst) begin
    if (rst)             acc <= '0;
    else if (first_beat) acc <= 32'(din);
    else if (!data_zero) acc <= acc + 32'(din);
  end

  // Monitor: handshake rules every cycle, sum checks on each consume, done timing.
  always @(negedge clk) begin
    if (scb_en && !rst) begin
      cyc++;
      check("data_zero", data_zero, !(beat_valid && beat_ready));
      if (first_beat) check("first_beat_needs_accept", beat_valid && beat_ready, 1);
      if (beat_valid && beat_ready && first_cyc < 0) first_cyc = cyc;
      if (done_due || done) begin
        check("done_pulse", done, done_due);
        if (done) done_cnt++;
        done_due = 1'b0;
      end
      if (out_valid && !out_ready) begin
        stall_obs++;
        check("hold_beat_ready", beat_ready, 0);
        check("hold_data_zero", data_zero, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sum", 1, 0);
        end else begin
          check("pixel_sum", acc, exp_q.pop_front());
          if (det_mode) check("sum_timing", 64'(cyc - first_cyc), 64'((popped + 1) * cur_b));
        end
        popped++;
        if (popped == cur_n) done_due = 1'b1;
      end
    end
  end

  // mode 0: random valid/ready with ignored mid-layer starts; 1: all ones;
  // 2: ready held low 5 cycles at first HOLD; 3: beat_valid pattern 1,0,0,1
  task automatic run_layer(input int b, input int n, input int mode);
    int eff_b, total, accepted, cnt, held, i, budget;
    logic [31:0] sum;
    eff_b = (b == 0) ? 1 : b;
    total = eff_b * n;
    accepted = 0; cnt = 0; held = 0; i = 0; sum = 0; budget = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_beats = CNT_W'(b); cfg_outputs = OUT_W'(n);
    cur_b = eff_b; cur_n = n; popped = 0; first_cyc = -1;
    det_mode = (mode == 1); done_cnt = 0; stall_obs = 0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_outputs = OUT_W'($urandom_range(0, 9));
    check("busy_after_start", busy, 1);
    while (popped < n) begin
      din = 16'($urandom);
      case (mode)
        1: begin beat_valid = 1'b1; out_ready = 1'b1; end
        2: begin
          beat_valid = 1'b1;
          if (out_valid && held < 5) begin out_ready = 1'b0; held++; end
          else out_ready = 1'b1;
        end
        3: begin beat_valid = (i % 4 == 0) || (i % 4 == 3); out_ready = 1'b1; end
        default: begin
          beat_valid = ($urandom_range(0, 3) != 0);
          out_ready  = ($urandom_range(0, 2) != 0);
          start      = ($urandom_range(0, 15) == 0);
        end
      endcase
      i++;
      #1;
      if (beat_valid && beat_ready) begin
        if (accepted == total) begin
          check("extra_beat_accepted", 1, 0);
        end else begin
          accepted++;
          sum = sum + 32'(din);
          cnt++;
          if (cnt == eff_b) begin
            exp_q.push_back(sum);
            sum = 0; cnt = 0;
          end
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      budget++;
      if (budget > 3000) begin
        check("layer_timeout", popped, n);
        break;
      end
    end
    beat_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("beats_accepted", accepted, total);
    check("done_count", done_cnt, 1);
    check("busy_after_done", busy, 0);
    check("queue_drained", exp_q.size(), 0);
`ifdef ACC_PERF_CNT_EN
    check("stall_cycles", stall_cycles, stall_obs);
    if (mode == 2) check("stall_five", stall_cycles, 5);
`else
    check("stall_tied_zero", stall_cycles, 0);
`endif
  endtask

  task automatic zero_layer(input int b);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_beats = CNT_W'(b); cfg_outputs = '0;
    @(posedge clk); #1;
    start = 1'b0;
    done_due = 1'b1;
    check("zero_outputs_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_outputs_done_count", done_cnt, 1);
    check("zero_outputs_idle", busy, 0);
  endtask

  task automatic reset_mid_run();
    @(posedge clk); #1;
    start = 1'b1; cfg_beats = CNT_W'(3); cfg_outputs = OUT_W'(2);
    @(posedge clk); #1;
    start = 1'b0; beat_valid = 1'b1; din = 16'd7;
    @(posedge clk); #1;
    scb_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_beat_ready", beat_ready, 0);
    check("rst_first_beat", first_beat, 0);
    check("rst_data_zero", data_zero, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall_cycles, 0);
    beat_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    done_due = 1'b0;
    #1 scb_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_beats = '0; cfg_outputs = '0;
    beat_valid = 1'b0; out_ready = 1'b0; din = '0;
    #3;
    check("reset_beat_ready", beat_ready, 0);
    check("reset_first_beat", first_beat, 0);
    check("reset_data_zero", data_zero, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stall", stall_cycles, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 scb_en = 1'b1;

    run_layer(3, 2, 1);
    run_layer(1, 4, 1);
    run_layer(2, 3, 2);
    run_layer(2, 2, 3);
    zero_layer(4);
    run_layer(0, 3, 1);
    for (int k = 0; k < 8; k++)
      run_layer($urandom_range(0, 5), $urandom_range(1, 6), 0);
    reset_mid_run();
    run_layer(3, 2, 1);
    run_layer(4, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
